// File: rtl/tetris_input_pkg.sv
// tetris_input_pkg: shared key indices, per-key state encoding and counter width for the input path.
package tetris_input_pkg;
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_ROT   = 2;
  localparam int KEY_DOWN  = 3;
  localparam int CNT_W     = 8;
  typedef enum logic [1:0] {IDLE, DEB, DELAY, REPEAT} key_state_t;
endpackage

// File: rtl/key_repeat_fsm.sv
// key_repeat_fsm: debounce and DAS/ARR auto-repeat for one key, advancing only on rate ticks.
module key_repeat_fsm
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int DAS_TICKS      = 4,
  parameter int ARR_TICKS      = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic ks,
  output logic pulse_req,
  output logic held
);
  key_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, lim;
  logic held_q;
  assign cnt_inc = cnt_q + 1'b1;
  assign lim = state_q == DEB   ? CNT_W'(DEBOUNCE_TICKS) :
               state_q == DELAY ? CNT_W'(DAS_TICKS) : CNT_W'(ARR_TICKS);
  assign held = held_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_req = 1'b0;
    if (tick && !ks) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (tick && state_q == IDLE && DEBOUNCE_TICKS > 1) begin
      state_d = DEB;
      cnt_d   = CNT_W'(1);
    end else if (tick && (state_q == IDLE || cnt_inc == lim)) begin
      pulse_req = 1'b1;
      cnt_d     = '0;
      state_d   = (state_q == DELAY || state_q == REPEAT) ? REPEAT : DELAY;
    end else if (tick) begin
      cnt_d = cnt_inc;
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= state_d == DELAY || state_d == REPEAT;
    end
endmodule

// File: rtl/key_repeat_ctrl.sv
// key_repeat_ctrl: turns the move-rate square wave into ticks and drives debounced, auto-repeating key strobes.
module key_repeat_ctrl
  import tetris_input_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int DEBOUNCE_TICKS = 2,
  parameter int DAS_TICKS      = 4,
  parameter int ARR_TICKS      = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                rate_clk_in,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic                tick_out,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_held
);
  localparam logic [NUM_KEYS-1:0] LR_MASK = NUM_KEYS'((1 << KEY_LEFT) | (1 << KEY_RIGHT));
  logic [2:0] rate_q;
  logic [NUM_KEYS-1:0] ks1_q, ks_q, req, pulse_d, pulse_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rate_q  <= '0;
      ks1_q   <= '0;
      ks_q    <= '0;
      pulse_q <= '0;
    end else begin
      rate_q  <= {rate_q[1:0], rate_clk_in};
      ks1_q   <= key_raw;
      ks_q    <= ks1_q;
      pulse_q <= pulse_d;
    end
  assign tick_out  = rate_q[1] & ~rate_q[2];
  // Simultaneous left and right cancel each other; their FSMs keep running.
  assign pulse_d   = (req[KEY_LEFT] & req[KEY_RIGHT]) ? req & ~LR_MASK : req;
  assign key_pulse = pulse_q;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_repeat_fsm #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .DAS_TICKS     (DAS_TICKS),
      .ARR_TICKS     (ARR_TICKS)
    ) u_fsm (
      .CLK      (CLK),
      .RST      (RST),
      .tick     (tick_out),
      .ks       (ks_q[k]),
      .pulse_req(req[k]),
      .held     (key_held[k])
    );
  end
endmodule

// File: tb/tb_key_repeat_ctrl.sv
// tb_key_repeat_ctrl: directed checks of tick generation, debounce, auto-repeat, exclusion and reset.
module tb_key_repeat_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rate = 1'b0;
  logic [3:0] key_raw = '0;
  logic tick_a, tick_b;
  logic [3:0] pulse_a, held_a, pulse_b, held_b;
  logic [3:0] prev_a = '0, prev_b = '0;
  int nvec = 0, nerr = 0, tcnt = 0, dbl = 0;
  int log_a[$], log_b[$], exp_q[$];

  key_repeat_ctrl dut_a (
    .CLK(clk), .RST(rst), .rate_clk_in(rate), .key_raw(key_raw),
    .tick_out(tick_a), .key_pulse(pulse_a), .key_held(held_a)
  );
  key_repeat_ctrl #(.NUM_KEYS(4), .DEBOUNCE_TICKS(1), .DAS_TICKS(3), .ARR_TICKS(2)) dut_b (
    .CLK(clk), .RST(rst), .rate_clk_in(rate), .key_raw(key_raw),
    .tick_out(tick_b), .key_pulse(pulse_b), .key_held(held_b)
  );

  always #5 clk = ~clk;

  // Pulses are logged as key*100 + index of the tick that produced them.
  always @(negedge clk) begin
    if (tick_a) tcnt++;
    for (int i = 0; i < 4; i++) begin
      if (pulse_a[i]) log_a.push_back(i * 100 + tcnt);
      if (pulse_b[i]) log_b.push_back(i * 100 + tcnt);
    end
    if ((pulse_a & prev_a) != 0 || (pulse_b & prev_b) != 0) dbl++;
    prev_a = pulse_a;
    prev_b = pulse_b;
  end

  task automatic run_ticks(input int n);
    repeat (n) begin
      rate = 1'b1;
      repeat (10) @(negedge clk);
      rate = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic start_test();
    log_a.delete();
    log_b.delete();
    tcnt = 0;
  endtask

  task automatic test_reset();
    rate = 1'b1;
    #1 rst = 1'b1;
    #1;
    nvec++; if (tick_a !== 1'b0) begin nerr++; $display("FAIL reset_tick_a: got %b want 0", tick_a); end
    nvec++; if (pulse_a !== 4'h0) begin nerr++; $display("FAIL reset_pulse_a: got %h want 0", pulse_a); end
    nvec++; if (held_a !== 4'h0) begin nerr++; $display("FAIL reset_held_a: got %h want 0", held_a); end
    nvec++; if (tick_b !== 1'b0) begin nerr++; $display("FAIL reset_tick_b: got %b want 0", tick_b); end
    nvec++; if (pulse_b !== 4'h0) begin nerr++; $display("FAIL reset_pulse_b: got %h want 0", pulse_b); end
    nvec++; if (held_b !== 4'h0) begin nerr++; $display("FAIL reset_held_b: got %h want 0", held_b); end
    repeat (3) @(negedge clk);
    nvec++; if (tick_a !== 1'b0) begin nerr++; $display("FAIL reset_hold_tick: got %b want 0", tick_a); end
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      nvec++; if (tick_a !== (c == 2)) begin nerr++; $display("FAIL release_tick c=%0d: got %b want %b", c, tick_a, c == 2); end
    end
    rate = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_rate_sync();
    start_test();
    for (int p = 0; p < 3; p++) begin
      rate = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        nvec++; if (tick_a !== (c == 2)) begin nerr++; $display("FAIL rate_tick p=%0d c=%0d: got %b want %b", p, c, tick_a, c == 2); end
        if (c == 10) rate = 1'b0;
      end
    end
    nvec++; if (tcnt !== 3) begin nerr++; $display("FAIL rate_tick_count: got %0d want 3", tcnt); end
  endtask

  task automatic test_hold_repeat();
    start_test();
    key_raw[2] = 1'b1;
    repeat (5) @(negedge clk);
    run_ticks(1);
    nvec++; if (held_a[2] !== 1'b0) begin nerr++; $display("FAIL hold_held_t1: got %b want 0", held_a[2]); end
    run_ticks(1);
    nvec++; if (held_a[2] !== 1'b1) begin nerr++; $display("FAIL hold_held_t2: got %b want 1", held_a[2]); end
    run_ticks(7);
    nvec++; if (held_a[2] !== 1'b1) begin nerr++; $display("FAIL hold_held_t9: got %b want 1", held_a[2]); end
    key_raw[2] = 1'b0;
    run_ticks(1);
    nvec++; if (held_a[2] !== 1'b0) begin nerr++; $display("FAIL hold_held_release: got %b want 0", held_a[2]); end
    exp_q = '{202, 206, 207, 208, 209};
    nvec++; if (log_a.size() !== exp_q.size()) begin nerr++; $display("FAIL hold_pulse_count: got %0d want %0d", log_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++; if (i >= log_a.size() || log_a[i] !== exp_q[i]) begin nerr++; $display("FAIL hold_pulse[%0d]: got %0d want %0d", i, i < log_a.size() ? log_a[i] : -1, exp_q[i]); end
    end
  endtask

  task automatic test_bounce();
    start_test();
    key_raw[3] = 1'b1;
    repeat (5) @(negedge clk);
    run_ticks(1);
    key_raw[3] = 1'b0;
    run_ticks(1);
    key_raw[3] = 1'b1;
    run_ticks(2);
    nvec++; if (held_a[3] !== 1'b1) begin nerr++; $display("FAIL bounce_held: got %b want 1", held_a[3]); end
    key_raw[3] = 1'b0;
    run_ticks(1);
    nvec++; if (held_a[3] !== 1'b0) begin nerr++; $display("FAIL bounce_release: got %b want 0", held_a[3]); end
    nvec++; if (log_a.size() !== 1) begin nerr++; $display("FAIL bounce_pulse_count: got %0d want 1", log_a.size()); end
    nvec++; if (log_a.size() < 1 || log_a[0] !== 304) begin nerr++; $display("FAIL bounce_pulse: got %0d want 304", log_a.size() > 0 ? log_a[0] : -1); end
  endtask

  task automatic test_lr_exclusion();
    start_test();
    key_raw[1:0] = 2'b11;
    repeat (5) @(negedge clk);
    run_ticks(7);
    nvec++; if (held_a[1:0] !== 2'b11) begin nerr++; $display("FAIL lr_held: got %b want 11", held_a[1:0]); end
    nvec++; if (log_a.size() !== 0) begin nerr++; $display("FAIL lr_suppressed: got %0d pulses want 0", log_a.size()); end
    key_raw[1] = 1'b0;
    run_ticks(3);
    nvec++; if (held_a[1] !== 1'b0) begin nerr++; $display("FAIL lr_right_release: got %b want 0", held_a[1]); end
    exp_q = '{8, 9, 10};
    nvec++; if (log_a.size() !== exp_q.size()) begin nerr++; $display("FAIL lr_pulse_count: got %0d want %0d", log_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++; if (i >= log_a.size() || log_a[i] !== exp_q[i]) begin nerr++; $display("FAIL lr_pulse[%0d]: got %0d want %0d", i, i < log_a.size() ? log_a[i] : -1, exp_q[i]); end
    end
    key_raw[0] = 1'b0;
    run_ticks(1);
  endtask

  task automatic test_reset_mid();
    start_test();
    key_raw[2] = 1'b1;
    repeat (5) @(negedge clk);
    run_ticks(7);
    rate = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (pulse_a[2] !== 1'b1) begin nerr++; $display("FAIL mid_pulse_before: got %b want 1", pulse_a[2]); end
    rst = 1'b1;
    #1;
    nvec++; if (pulse_a !== 4'h0) begin nerr++; $display("FAIL mid_pulse_async: got %h want 0", pulse_a); end
    nvec++; if (held_a !== 4'h0) begin nerr++; $display("FAIL mid_held_async: got %h want 0", held_a); end
    nvec++; if (held_b !== 4'h0) begin nerr++; $display("FAIL mid_held_b_async: got %h want 0", held_b); end
    rate = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    start_test();
    run_ticks(1);
    nvec++; if (held_a[2] !== 1'b0) begin nerr++; $display("FAIL mid_held_t1: got %b want 0", held_a[2]); end
    nvec++; if (log_a.size() !== 0) begin nerr++; $display("FAIL mid_no_early_pulse: got %0d want 0", log_a.size()); end
    run_ticks(1);
    nvec++; if (held_a[2] !== 1'b1) begin nerr++; $display("FAIL mid_held_t2: got %b want 1", held_a[2]); end
    nvec++; if (log_a.size() !== 1 || log_a[0] !== 202) begin nerr++; $display("FAIL mid_first_pulse: got %0d want 202", log_a.size() > 0 ? log_a[0] : -1); end
    key_raw[2] = 1'b0;
    run_ticks(1);
  endtask

  task automatic test_param_sweep();
    start_test();
    key_raw[2] = 1'b1;
    repeat (5) @(negedge clk);
    run_ticks(1);
    nvec++; if (held_b[2] !== 1'b1) begin nerr++; $display("FAIL sweep_held_t1: got %b want 1", held_b[2]); end
    run_ticks(7);
    key_raw[2] = 1'b0;
    run_ticks(1);
    nvec++; if (held_b[2] !== 1'b0) begin nerr++; $display("FAIL sweep_release: got %b want 0", held_b[2]); end
    exp_q = '{201, 204, 206, 208};
    nvec++; if (log_b.size() !== exp_q.size()) begin nerr++; $display("FAIL sweep_pulse_count: got %0d want %0d", log_b.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++; if (i >= log_b.size() || log_b[i] !== exp_q[i]) begin nerr++; $display("FAIL sweep_pulse[%0d]: got %0d want %0d", i, i < log_b.size() ? log_b[i] : -1, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    nvec++; if (dbl !== 0) begin nerr++; $display("FAIL pulse_back_to_back: got %0d want 0", dbl); end
  endtask

  initial begin
    test_reset();
    test_rate_sync();
    test_hold_repeat();
    test_bounce();
    test_lr_exclusion();
    test_reset_mid();
    test_param_sweep();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
